// File: rtl/sha2_ipu_datapath.sv
// -----------------------------------------------------------------------------
// sha2_ipu_datapath
//
// Datapath of the SHA-2 input processing unit. Assembles 64-bit message packets
// into a 512-bit block (eight 64-bit words, word 0 most significant) and inserts
// SHA-2 padding words under command of the IPU control FSM.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_b     in   1   asynchronous reset, active-high (clears all state)
//   clr       in   1   synchronous clear of all state
//   pkt       in  64   input message packet
//   st_pkt    in   1   store pkt into word[idx], add 64 to the message length
//   pad_pkt   in   1   store padding marker 64'h8000_0000_0000_0000
//   zero_pkt  in   1   store 64'h0
//   mgln_pkt  in   1   store the message length in bits (pre-edge value)
//   blk       out 512  assembled block, word k at blk[511-64k -: 64]
//   idx       out  3   index of the next word slot to be written
//
// Commands are prioritised clr > st_pkt > pad_pkt > zero_pkt > mgln_pkt; the
// losing commands in a cycle have no effect at all.
// -----------------------------------------------------------------------------
module sha2_ipu_datapath (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic [63:0]  pkt,
    input  logic         st_pkt,
    input  logic         pad_pkt,
    input  logic         zero_pkt,
    input  logic         mgln_pkt,
    output logic [511:0] blk,
    output logic [2:0]   idx
);

    localparam int unsigned NumWords  = 8;
    localparam int unsigned WordWidth = 64;

    localparam logic [WordWidth-1:0] PadMarker = 64'h8000_0000_0000_0000;
    localparam logic [WordWidth-1:0] PktBits   = 64'd64;

    typedef enum logic [2:0] {
        CmdNone,
        CmdClr,
        CmdStore,
        CmdPad,
        CmdZero,
        CmdLen
    } cmd_e;

    logic [WordWidth-1:0] words_q [NumWords];
    logic [WordWidth-1:0] words_d [NumWords];
    logic [2:0]           idx_q,    idx_d;
    logic [WordWidth-1:0] msglen_q, msglen_d;

    cmd_e                 cmd;
    logic                 wr_en;
    logic [WordWidth-1:0] wr_data;

    // Priority decode of the command strobes into a single command.
    always_comb begin
        cmd = CmdNone;
        if (clr) begin
            cmd = CmdClr;
        end else if (st_pkt) begin
            cmd = CmdStore;
        end else if (pad_pkt) begin
            cmd = CmdPad;
        end else if (zero_pkt) begin
            cmd = CmdZero;
        end else if (mgln_pkt) begin
            cmd = CmdLen;
        end
    end

    // Data to be written into the current slot; wr_en gates the slot write.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        unique case (cmd)
            CmdStore: begin
                wr_en   = 1'b1;
                wr_data = pkt;
            end
            CmdPad: begin
                wr_en   = 1'b1;
                wr_data = PadMarker;
            end
            CmdZero: begin
                wr_en   = 1'b1;
                wr_data = '0;
            end
            CmdLen: begin
                wr_en   = 1'b1;
                wr_data = msglen_q;
            end
            default: begin
                wr_en   = 1'b0;
                wr_data = '0;
            end
        endcase
    end

    // Next-state: only word[idx] changes on a write, idx wraps 7 -> 0 and the
    // length keeps counting across blocks until clr or reset.
    always_comb begin
        for (int i = 0; i < NumWords; i++) begin
            words_d[i] = words_q[i];
        end
        idx_d    = idx_q;
        msglen_d = msglen_q;

        if (cmd == CmdClr) begin
            for (int i = 0; i < NumWords; i++) begin
                words_d[i] = '0;
            end
            idx_d    = '0;
            msglen_d = '0;
        end else if (wr_en) begin
            words_d[idx_q] = wr_data;
            idx_d          = idx_q + 3'd1;
            if (cmd == CmdStore) begin
                msglen_d = msglen_q + PktBits;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < NumWords; i++) begin
                words_q[i] <= '0;
            end
            idx_q    <= '0;
            msglen_q <= '0;
        end else begin
            for (int i = 0; i < NumWords; i++) begin
                words_q[i] <= words_d[i];
            end
            idx_q    <= idx_d;
            msglen_q <= msglen_d;
        end
    end

    for (genvar k = 0; k < NumWords; k++) begin : g_blk
        assign blk[511 - 64*k -: 64] = words_q[k];
    end

    assign idx = idx_q;

endmodule

// File: tb/tb_sha2_ipu_datapath.sv
// -----------------------------------------------------------------------------
// tb_sha2_ipu_datapath
//
// Self-checking bench for sha2_ipu_datapath. A behavioural model (word array,
// integer slot counter, integer bit-length) tracks the expected block; directed
// steps follow the block's intended use, then a randomized command phase runs.
// -----------------------------------------------------------------------------
module tb_sha2_ipu_datapath;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         clr;
    logic [63:0]  pkt;
    logic         st_pkt;
    logic         pad_pkt;
    logic         zero_pkt;
    logic         mgln_pkt;
    logic [511:0] blk;
    logic [2:0]   idx;

    sha2_ipu_datapath dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr      (clr),
        .pkt      (pkt),
        .st_pkt   (st_pkt),
        .pad_pkt  (pad_pkt),
        .zero_pkt (zero_pkt),
        .mgln_pkt (mgln_pkt),
        .blk      (blk),
        .idx      (idx)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0]    m_words [8];
    int unsigned    m_idx;
    longint unsigned m_len;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_words[i] = 64'h0;
        m_idx = 0;
        m_len = 0;
    endfunction

    function automatic void model_step(input logic c, input logic st, input logic pd,
                                       input logic zr, input logic ml, input logic [63:0] p);
        if (c) begin
            model_clear();
        end else if (st) begin
            m_words[m_idx] = p;
            m_idx          = (m_idx + 1) % 8;
            m_len          = m_len + 64;
        end else if (pd) begin
            m_words[m_idx] = 64'h8000_0000_0000_0000;
            m_idx          = (m_idx + 1) % 8;
        end else if (zr) begin
            m_words[m_idx] = 64'h0;
            m_idx          = (m_idx + 1) % 8;
        end else if (ml) begin
            m_words[m_idx] = m_len;
            m_idx          = (m_idx + 1) % 8;
        end
    endfunction

    task automatic check_model(input string tag);
        logic [511:0] exp_blk;
        logic [2:0]   exp_idx;
        for (int k = 0; k < 8; k++) exp_blk[511 - 64*k -: 64] = m_words[k];
        exp_idx = 3'(m_idx);
        n_cmp++;
        assert (blk === exp_blk) else begin
            n_fail++;
            $error("FAIL %s blk: got %h expected %h", tag, blk, exp_blk);
        end
        n_cmp++;
        assert (idx === exp_idx) else begin
            n_fail++;
            $error("FAIL %s idx: got %0d expected %0d", tag, idx, exp_idx);
        end
    endtask

    task automatic check_word(input string tag, input int k, input logic [63:0] exp_w);
        logic [63:0] got;
        got = blk[511 - 64*k -: 64];
        n_cmp++;
        assert (got === exp_w) else begin
            n_fail++;
            $error("FAIL %s word%0d: got %h expected %h", tag, k, got, exp_w);
        end
    endtask

    task automatic check_idx(input string tag, input logic [2:0] exp_i);
        n_cmp++;
        assert (idx === exp_i) else begin
            n_fail++;
            $error("FAIL %s idx: got %0d expected %0d", tag, idx, exp_i);
        end
    endtask

    // One clock of stimulus: drive on negedge, sample 1 time unit after posedge.
    task automatic drive(input string tag, input logic c, input logic st, input logic pd,
                         input logic zr, input logic ml, input logic [63:0] p);
        @(negedge clk);
        clr      = c;
        st_pkt   = st;
        pad_pkt  = pd;
        zero_pkt = zr;
        mgln_pkt = ml;
        pkt      = p;
        @(posedge clk);
        model_step(c, st, pd, zr, ml, p);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom});
    endtask

    task automatic store(input string tag, input logic [63:0] p);
        drive(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p);
    endtask

    initial begin
        logic [63:0] fill [8];

        rst_b    = 1'b1;
        clr      = 1'b0;
        st_pkt   = 1'b0;
        pad_pkt  = 1'b0;
        zero_pkt = 1'b0;
        mgln_pkt = 1'b0;
        pkt      = {$urandom, $urandom};
        model_clear();

        // Reset is asynchronous: outputs clear before any clock edge.
        #2;
        check_word("rst_async", 0, 64'h0);
        check_model("rst_async");
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) idle("idle_after_rst");

        // Eight stores 1111.. to 8888.., idx steps 1..7 then 0.
        for (int i = 0; i < 8; i++) begin
            store("fill8", {16{4'(i + 1)}});
            check_idx("fill8_idx", 3'(i + 1));
        end
        check_word("fill8_w0", 0, 64'h1111_1111_1111_1111);
        check_word("fill8_w7", 7, 64'h8888_8888_8888_8888);
        drive("len512", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        check_word("len512", 0, 64'h200);

        // Three stores then padding sequence.
        drive("clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) store("pad_seq_st", {$urandom, $urandom});
        drive("pad_seq_pad", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        for (int i = 0; i < 3; i++)
            drive("pad_seq_zero", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {$urandom, $urandom});
        drive("pad_seq_len", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        check_word("pad_w3", 3, 64'h8000_0000_0000_0000);
        check_word("pad_w4", 4, 64'h0);
        check_word("pad_w7", 7, 64'h0000_0000_0000_00C0);
        check_idx("pad_idx", 3'd0);

        // Priority: st_pkt beats pad_pkt; clr beats st_pkt.
        drive("clr2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        drive("st_vs_pad", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        check_word("st_vs_pad", 0, 64'hDEAD_BEEF_CAFE_F00D);
        drive("len64", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
        check_word("len64", 1, 64'h40);
        drive("clr_vs_st", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {$urandom, $urandom});
        check_word("clr_vs_st", 0, 64'h0);
        check_idx("clr_vs_st", 3'd0);

        // Wrap: ninth store overwrites only word 0.
        for (int i = 0; i < 8; i++) begin
            fill[i] = {$urandom, $urandom};
            store("wrap_fill", fill[i]);
        end
        store("wrap_ninth", {16{4'hA, 4'h5}} );
        check_word("wrap_w0", 0, {16{4'hA, 4'h5}});
        check_word("wrap_w1", 1, fill[1]);
        check_word("wrap_w7", 7, fill[7]);
        check_idx("wrap_idx", 3'd1);

        // Reset mid-fill at idx 5.
        drive("clr3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) store("midfill", {$urandom, $urandom});
        check_idx("midfill_idx", 3'd5);
        @(negedge clk);
        rst_b  = 1'b1;
        st_pkt = 1'b1;
        pkt    = {$urandom, $urandom};
        #1;
        model_clear();
        check_model("midfill_rst");
        @(negedge clk);
        rst_b  = 1'b0;
        st_pkt = 1'b0;
        drive("post_rst_len", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        check_word("post_rst_len", 0, 64'h0);
        check_idx("post_rst_len", 3'd1);

        // Randomized command mix against the model.
        for (int i = 0; i < 400; i++) begin
            drive("rand", ($urandom_range(0, 99) < 3), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
